a23_cp15_ctrl: RTL and testbench

- Parametrised CP15 system-control block for the a23 core.
- Extends the single-word control registers to AREA_WORDS words, so the cacheable, updateable and disruptive maps each cover 32*AREA_WORDS 2MB regions.
- Replaces the single fault latch with a FAULT_DEPTH-entry fault FIFO, popped by reading it.
- Turns cache flush into a req/ack handshake with the cache.
- Sits between the core's coprocessor interface and the cache/AXI bridge.

---
 rtl/a23_cp15_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_a23_cp15_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/a23_cp15_ctrl.sv
// CP15 system-control block for the a23 core: control/area registers, fault FIFO
// and a req/ack cache-flush handshake between the coprocessor port and the cache.
module a23_cp15_ctrl #(
   parameter int          AREA_WORDS  = 1,
   parameter int          FAULT_DEPTH = 4,
   parameter logic [31:0] ID_VALUE    = 32'h4156_0301
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_fetch_stall,
   input  logic [3:0]              i_copro_crn,
   input  logic [3:0]              i_copro_crm,
   input  logic [1:0]              i_copro_operation,
   input  logic [31:0]             i_copro_write_data,
   input  logic                    i_fault,
   input  logic [7:0]              i_fault_status,
   input  logic [31:0]             i_fault_address,
   input  logic                    i_flush_ack,
   output logic [31:0]             o_copro_read_data,
   output logic                    o_cache_enable,
   output logic                    o_flush_req,
   output logic [32*AREA_WORDS-1:0] o_cacheable_area,
   output logic [32*AREA_WORDS-1:0] o_updateable_area,
   output logic [32*AREA_WORDS-1:0] o_disruptive_area,
   output logic                    o_fault_pending
);
   // state | meaning
   // IDLE  | no flush outstanding
   // REQ   | flush requested, waiting for ack
   // PEND  | ack and new request coincided; req dropped for one cycle
   typedef enum logic [1:0] {IDLE, REQ, PEND} flush_state_t;

   localparam int PW = $clog2(FAULT_DEPTH);
   localparam int CW = $clog2(FAULT_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FAULT_DEPTH);

   flush_state_t  flush_state;
   logic [2:0]    cache_control;
   logic [31:0]   cacheable  [AREA_WORDS];
   logic [31:0]   updateable [AREA_WORDS];
   logic [31:0]   disruptive [AREA_WORDS];
   logic [7:0]    fifo_status  [FAULT_DEPTH];
   logic [31:0]   fifo_address [FAULT_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic        mcr, mrc, clear, pop, push_ok, drop, full, empty;
   logic [31:0] area_value, read_value;

   always_comb begin
      mcr     = !i_fetch_stall && (i_copro_operation == 2'd2);
      mrc     = !i_fetch_stall && (i_copro_operation == 2'd1);
      full    = (count == FULL);
      empty   = (count == '0);
      clear   = mcr && (i_copro_crn == 4'd8);
      pop     = mrc && (i_copro_crn == 4'd7) && !empty;
      // A simultaneous pop frees the slot a full-FIFO push needs
      push_ok = i_fault && !clear && (!full || pop);
      drop    = i_fault && !clear && full && !pop;
   end

   always_comb begin
      area_value = '0;
      for (int i = 0; i < AREA_WORDS; i++) begin
         if (i_copro_crm == 4'(i)) begin
            case (i_copro_crn)
               4'd3:    area_value = cacheable[i];
               4'd4:    area_value = updateable[i];
               4'd5:    area_value = disruptive[i];
               default: area_value = '0;
            endcase
         end
      end
   end

   always_comb begin
      case (i_copro_crn)
         4'd0:             read_value = ID_VALUE;
         4'd2:             read_value = {29'd0, cache_control};
         4'd3, 4'd4, 4'd5: read_value = area_value;
         4'd6:             read_value = empty ? 32'd0 : {24'd0, fifo_status[rd_ptr]};
         4'd7:             read_value = empty ? 32'd0 : fifo_address[rd_ptr];
         4'd8:             read_value = {overflow, 23'd0, 8'(count)};
         default:          read_value = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_copro_read_data <= '0;
         cache_control     <= '0;
         for (int i = 0; i < AREA_WORDS; i++) begin
            cacheable[i]  <= '0;
            updateable[i] <= '0;
            disruptive[i] <= '0;
         end
      end else if (!i_fetch_stall) begin
         o_copro_read_data <= read_value;
         if (mcr && i_copro_crn == 4'd2)
            cache_control <= i_copro_write_data[2:0];
         for (int i = 0; i < AREA_WORDS; i++) begin
            if (mcr && i_copro_crm == 4'(i)) begin
               case (i_copro_crn)
                  4'd3:    cacheable[i]  <= i_copro_write_data;
                  4'd4:    updateable[i] <= i_copro_write_data;
                  4'd5:    disruptive[i] <= i_copro_write_data;
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FAULT_DEPTH; i++) begin
            fifo_status[i]  <= '0;
            fifo_address[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (drop)
            overflow <= 1'b1;
         if (push_ok) begin
            fifo_status[wr_ptr]  <= i_fault_status;
            fifo_address[wr_ptr] <= i_fault_address;
            wr_ptr               <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         flush_state <= IDLE;
         o_flush_req <= 1'b0;
      end else begin
         case (flush_state)
            IDLE: if (mcr && i_copro_crn == 4'd1) begin
               flush_state <= REQ;
               o_flush_req <= 1'b1;
            end
            REQ: if (i_flush_ack) begin
               flush_state <= (mcr && i_copro_crn == 4'd1) ? PEND : IDLE;
               o_flush_req <= 1'b0;
            end
            PEND: begin
               flush_state <= REQ;
               o_flush_req <= 1'b1;
            end
            default: begin
               flush_state <= IDLE;
               o_flush_req <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < AREA_WORDS; g++) begin : g_area
      assign o_cacheable_area[32*g +: 32]  = cacheable[g];
      assign o_updateable_area[32*g +: 32] = updateable[g];
      assign o_disruptive_area[32*g +: 32] = disruptive[g];
   end

   assign o_cache_enable  = cache_control[0];
   assign o_fault_pending = !empty;
endmodule

// File: tb/tb_a23_cp15_ctrl.sv
// Directed bench for a23_cp15_ctrl with two area words: registers, fault FIFO,
// flush handshake, stall qualification and asynchronous reset.
module tb_a23_cp15_ctrl;
   localparam logic [31:0] ID = 32'h4156_0301;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic [3:0]  crn, crm;
   logic [1:0]  op;
   logic [31:0] wdata;
   logic        fault;
   logic [7:0]  fstatus;
   logic [31:0] faddr;
   logic        ack;
   logic [31:0] rdata;
   logic        cache_en, flush_req, pending;
   logic [63:0] cacheable, updateable, disruptive;

   int checks = 0;
   int fails  = 0;

   a23_cp15_ctrl #(.AREA_WORDS(2), .FAULT_DEPTH(4), .ID_VALUE(ID)) dut (
      .i_clk              (clk),
      .i_rstn             (rstn),
      .i_fetch_stall      (stall),
      .i_copro_crn        (crn),
      .i_copro_crm        (crm),
      .i_copro_operation  (op),
      .i_copro_write_data (wdata),
      .i_fault            (fault),
      .i_fault_status     (fstatus),
      .i_fault_address    (faddr),
      .i_flush_ack        (ack),
      .o_copro_read_data  (rdata),
      .o_cache_enable     (cache_en),
      .o_flush_req        (flush_req),
      .o_cacheable_area   (cacheable),
      .o_updateable_area  (updateable),
      .o_disruptive_area  (disruptive),
      .o_fault_pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] o, input logic [3:0] n, input logic [3:0] m,
                        input logic [31:0] d);
      op = o; crn = n; crm = m; wdata = d;
   endtask

   initial begin
      rstn = 1'b0; stall = 1'b0; fault = 1'b0; fstatus = '0; faddr = '0; ack = 1'b0;
      drive(2'd0, 4'd0, 4'd0, 32'd0);
      #12;
      check("reset_rdata", 64'(rdata), 64'd0);
      check("reset_flush", 64'(flush_req), 64'd0);
      check("reset_pending", 64'(pending), 64'd0);
      check("reset_cacheable", cacheable, 64'd0);
      rstn = 1'b1;

      // area maps
      drive(2'd2, 4'd3, 4'd1, 32'hDEAD_BEEF); cyc();
      check("cacheable_w1", cacheable, 64'hDEADBEEF_00000000);
      drive(2'd0, 4'd3, 4'd1, 32'd0); cyc();
      check("read_crn3_crm1", 64'(rdata), 64'hDEADBEEF);
      drive(2'd2, 4'd3, 4'd5, 32'h1234_5678); cyc();
      check("cacheable_oob", cacheable, 64'hDEADBEEF_00000000);
      check("read_crn3_crm5", 64'(rdata), 64'd0);
      drive(2'd2, 4'd4, 4'd0, 32'hA5A5_A5A5); cyc();
      check("updateable_w0", updateable, 64'h00000000_A5A5A5A5);
      drive(2'd2, 4'd5, 4'd1, 32'h0F0F_0000); cyc();
      check("disruptive_w1", disruptive, 64'h0F0F0000_00000000);
      drive(2'd0, 4'd0, 4'd0, 32'd0); cyc();
      check("read_id", 64'(rdata), 64'(ID));
      drive(2'd2, 4'd2, 4'd0, 32'hFFFF_FFF5); cyc();
      check("cache_enable_set", 64'(cache_en), 64'd1);
      drive(2'd2, 4'd2, 4'd0, 32'd0); cyc();
      check("read_crn2", 64'(rdata), 64'd5);
      check("cache_enable_clr", 64'(cache_en), 64'd0);

      // fill the FIFO, then overflow it
      drive(2'd0, 4'd8, 4'd0, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         fault = 1'b1; fstatus = 8'(i); faddr = 32'(i * 256); cyc();
      end
      fault = 1'b0;
      check("pending_full", 64'(pending), 64'd1);
      cyc();
      check("crn8_overflow", 64'(rdata), 64'h80000004);
      crn = 4'd6; cyc();
      check("crn6_head", 64'(rdata), 64'd1);
      drive(2'd1, 4'd7, 4'd0, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("pop_addr", 64'(rdata), 64'(i * 256));
         check("pop_pending", 64'(pending), (i == 4) ? 64'd0 : 64'd1);
      end
      cyc();
      check("pop_empty", 64'(rdata), 64'd0);
      drive(2'd0, 4'd8, 4'd0, 32'd0); cyc();
      check("crn8_sticky", 64'(rdata), 64'h80000000);
      drive(2'd2, 4'd8, 4'd0, 32'd0); cyc();
      drive(2'd0, 4'd8, 4'd0, 32'd0); cyc();
      check("crn8_cleared", 64'(rdata), 64'd0);

      // full FIFO: push and pop together
      for (int i = 1; i <= 4; i++) begin
         fault = 1'b1; fstatus = 8'(i); faddr = 32'(i * 256); cyc();
      end
      fstatus = 8'd9; faddr = 32'h900; drive(2'd1, 4'd7, 4'd0, 32'd0); cyc();
      fault = 1'b0;
      check("full_pushpop_read", 64'(rdata), 64'h100);
      drive(2'd0, 4'd8, 4'd0, 32'd0); cyc();
      check("full_pushpop_count", 64'(rdata), 64'h4);

      // clear beats a simultaneous push
      drive(2'd2, 4'd8, 4'd0, 32'd0); fault = 1'b1; fstatus = 8'h44; faddr = 32'h444; cyc();
      fault = 1'b0; drive(2'd0, 4'd8, 4'd0, 32'd0);
      check("clear_wins_pending", 64'(pending), 64'd0);
      cyc();
      check("clear_wins_count", 64'(rdata), 64'd0);

      // push into empty FIFO while reading crn7
      fault = 1'b1; fstatus = 8'h33; faddr = 32'hABC; drive(2'd1, 4'd7, 4'd0, 32'd0); cyc();
      fault = 1'b0;
      check("empty_push_read", 64'(rdata), 64'd0);
      check("empty_push_pending", 64'(pending), 64'd1);
      cyc();
      check("empty_push_pop", 64'(rdata), 64'hABC);
      check("empty_push_drained", 64'(pending), 64'd0);

      // flush handshake
      drive(2'd2, 4'd1, 4'd0, 32'd0); cyc();
      check("flush_req_set", 64'(flush_req), 64'd1);
      cyc();
      check("flush_coalesce", 64'(flush_req), 64'd1);
      drive(2'd0, 4'd0, 4'd0, 32'd0); ack = 1'b1; cyc(); ack = 1'b0;
      check("flush_ack", 64'(flush_req), 64'd0);
      ack = 1'b1; cyc(); ack = 1'b0;
      check("flush_ack_idle", 64'(flush_req), 64'd0);
      drive(2'd2, 4'd1, 4'd0, 32'd0); cyc();
      check("flush_req_again", 64'(flush_req), 64'd1);
      ack = 1'b1; cyc(); ack = 1'b0; drive(2'd0, 4'd0, 4'd0, 32'd0);
      check("flush_pend_low", 64'(flush_req), 64'd0);
      cyc();
      check("flush_pend_reassert", 64'(flush_req), 64'd1);
      ack = 1'b1; cyc(); ack = 1'b0;
      check("flush_final_ack", 64'(flush_req), 64'd0);

      // stall qualification
      check("pre_stall_rdata", 64'(rdata), 64'(ID));
      stall = 1'b1; drive(2'd2, 4'd2, 4'd0, 32'd1);
      fault = 1'b1; fstatus = 8'h07; faddr = 32'h700; cyc();
      fault = 1'b0;
      check("stall_cache_en", 64'(cache_en), 64'd0);
      check("stall_rdata_held", 64'(rdata), 64'(ID));
      check("stall_fault_pushed", 64'(pending), 64'd1);
      stall = 1'b0; drive(2'd0, 4'd8, 4'd0, 32'd0); cyc();
      check("stall_count", 64'(rdata), 64'd1);

      // asynchronous reset mid-flush with two queued faults
      fault = 1'b1; fstatus = 8'h08; faddr = 32'h800; drive(2'd2, 4'd1, 4'd0, 32'd0); cyc();
      fault = 1'b0; drive(2'd0, 4'd8, 4'd0, 32'd0); cyc();
      check("pre_reset_req", 64'(flush_req), 64'd1);
      check("pre_reset_count", 64'(rdata), 64'd2);
      #2 rstn = 1'b0;
      #1;
      check("async_reset_req", 64'(flush_req), 64'd0);
      check("async_reset_pending", 64'(pending), 64'd0);
      check("async_reset_rdata", 64'(rdata), 64'd0);
      rstn = 1'b1;
      cyc();
      check("post_reset_count", 64'(rdata), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
